// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared widths, FSM state encoding and helpers for the
// memory-port round-robin arbiter.
//   N_REQ    number of requesters sharing the port
//   SEL_W    width of the port mux select
//   ST_*     FSM state encoding
package mem_arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   // One-hot grant vector for a requester index.
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/grant bundle between the pipeline requesters,
// the shared memory port and the arbiter.
//   req      level request per requester (bit i = requester i)
//   done     1-cycle completion pulse from the shared port
//   gnt      one-hot grant
//   sel      mux select = index of current/last winner
//   busy     a grant is active
//   timeout  1-cycle pulse on forced release
// Modports: master = arbiter side, slave = requester/port side.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             timeout;

   modport master (
      input  req, done,
      output gnt, sel, busy, timeout
   );

   modport slave (
      output req, done,
      input  gnt, sel, busy, timeout
   );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// rr_priority_pick: combinational rotate-by-ptr priority encoder. Returns the
// first set request found searching ptr, ptr+1, ... modulo N_REQ.
//   req    request vector
//   ptr    highest-priority index
//   valid  any request set
//   idx    winning index (ptr when no request is set)
module rr_priority_pick
   import mem_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             valid,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   // Scan from farthest offset down so the nearest set bit after ptr wins.
   always_comb begin
      valid = |req;
      idx   = ptr;
      cand  = ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = ptr + SEL_W'(i);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between four
// requesters (0 fetch, 1 load/store, 2 debug, 3 spare). Grants are held until
// the port signals done; re-arbitration on done has no bubble.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mem_port_arbiter_if.master (req, done in; gnt, sel, busy, timeout out)
// Parameters:
//   HOLD_MAX  max grant hold cycles before forced release (ARB_TIMEOUT_EN only)
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
// Build option: define ARB_TIMEOUT_EN to enable the hold timeout; otherwise
// timeout is tied low and a grant is held until done.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 255,
   parameter int unsigned CNT_W    = 8
)(
   input  logic                 clk,
   input  logic                 rst_n,
   mem_port_arbiter_if.master   bus
);

   // Reject configurations the hold counter cannot represent.
   if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_cfg
      $error("mem_port_arbiter: HOLD_MAX must be >= 1 and < 2**CNT_W");
   end

   logic             state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             busy_q, busy_d;

   logic [SEL_W-1:0] pick_ptr_c;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_valid;
   logic             complete_c;

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};

   logic [CNT_W-1:0] hold_q, hold_d;
   logic             timeout_q, timeout_d;
   logic             expire_c;

   // Limit reached without done: the timeout pulse acts as the completion.
   assign expire_c   = (state_q == ST_GRANT) && !bus.done && !timeout_q &&
                       (hold_q == HOLD_LAST);
   assign complete_c = bus.done | timeout_q;
`else
   assign complete_c = bus.done;
`endif

   // On completion, arbitrate this cycle with the rotated pointer.
   assign pick_ptr_c = (state_q == ST_GRANT && complete_c) ? sel_q + SEL_W'(1) : ptr_q;

   rr_priority_pick u_pick (
      .req   (bus.req),
      .ptr   (pick_ptr_c),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pick_valid) state_d = ST_GRANT;
         ST_GRANT: if (complete_c && !pick_valid) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, pointer and hold counter.
   always_comb begin
      gnt_d  = gnt_q;
      sel_d  = sel_q;
      busy_d = busy_q;
      ptr_d  = ptr_q;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = expire_c;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               gnt_d  = idx_to_onehot(pick_idx);
               sel_d  = pick_idx;
               busy_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_d = '0;
`endif
            end else begin
               gnt_d  = '0;
               busy_d = 1'b0;
            end
         end
         ST_GRANT: begin
            if (complete_c) begin
               ptr_d = sel_q + SEL_W'(1);
               if (pick_valid) begin
                  gnt_d  = idx_to_onehot(pick_idx);
                  sel_d  = pick_idx;
                  busy_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                  hold_d = '0;
`endif
               end else begin
                  gnt_d  = '0;
                  busy_d = 1'b0;
               end
            end else begin
`ifdef ARB_TIMEOUT_EN
               if (hold_q != HOLD_SAT) hold_d = hold_q + CNT_W'(1);
`endif
            end
         end
         default: begin
            gnt_d  = '0;
            busy_d = 1'b0;
         end
      endcase
   end

   // Output, pointer and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_q  <= '0;
         sel_q  <= '0;
         busy_q <= 1'b0;
         ptr_q  <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         gnt_q  <= gnt_d;
         sel_q  <= sel_d;
         busy_q <= busy_d;
         ptr_q  <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;
`ifdef ARB_TIMEOUT_EN
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// With ARB_TIMEOUT_EN the DUT is built with HOLD_MAX=4 and the forced
// release is checked; otherwise the grant must persist without done.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned HM = 4;
`else
   localparam int unsigned HM = 255;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.HOLD_MAX(HM), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic b);
      check_val({tag, ".gnt"},  32'(bus.gnt),  32'(g));
      check_val({tag, ".sel"},  32'(bus.sel),  32'(s));
      check_val({tag, ".busy"}, 32'(bus.busy), 32'(b));
   endtask

   task automatic do_reset;
      rst_n    = 1'b0;
      bus.req  = 4'b0000;
      bus.done = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [1:0] exp_sel;

   initial begin
      bus.req  = 4'b1111;
      bus.done = 1'b0;

      // Reset held with all requests active.
      rst_n = 1'b0;
      tick();
      tick();
      check_out("rst", 4'b0000, 2'd0, 1'b0);
      check_val("rst.timeout", 32'(bus.timeout), 32'd0);
      rst_n = 1'b1;
      tick();
      check_out("rst_rel", 4'b0001, 2'd0, 1'b1);

      // Single requester, release to idle, done in idle ignored.
      do_reset();
      bus.req = 4'b0100;
      tick();
      check_out("single", 4'b0100, 2'd2, 1'b1);
      bus.req  = 4'b0000;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_out("single_rel", 4'b0000, 2'd2, 1'b0);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_out("idle_done", 4'b0000, 2'd2, 1'b0);

      // Fairness: all requesting, done every 3rd cycle.
      do_reset();
      bus.req = 4'b1111;
      tick();
      check_out("fair0", 4'b0001, 2'd0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         exp_sel = 2'(k % 4);
         tick();
         check_val("fair_busy_a", 32'(bus.busy), 32'd1);
         tick();
         check_val("fair_busy_b", 32'(bus.busy), 32'd1);
         bus.done = 1'b1;
         tick();
         bus.done = 1'b0;
         check_out("fair", idx_to_onehot(exp_sel), exp_sel, 1'b1);
      end

      // Hold-through: winner drops req before done.
      do_reset();
      bus.req = 4'b0010;
      tick();
      check_out("hold0", 4'b0010, 2'd1, 1'b1);
      bus.req = 4'b1000;
      tick();
      check_out("hold1", 4'b0010, 2'd1, 1'b1);
      tick();
      check_out("hold2", 4'b0010, 2'd1, 1'b1);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_out("hold_next", 4'b1000, 2'd3, 1'b1);

      // Lone re-request stays granted; newcomer wins at next done.
      do_reset();
      bus.req = 4'b0001;
      tick();
      check_out("lone0", 4'b0001, 2'd0, 1'b1);
      bus.done = 1'b1;
      tick();
      check_out("lone1", 4'b0001, 2'd0, 1'b1);
      bus.done = 1'b0;
      tick();
      check_out("lone2", 4'b0001, 2'd0, 1'b1);
      bus.req = 4'b0011;
      tick();
      check_out("lone3", 4'b0001, 2'd0, 1'b1);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_out("lone_new", 4'b0010, 2'd1, 1'b1);

      // Hold timeout (or indefinite hold without the option).
      do_reset();
      bus.req = 4'b0100;
      tick();
      check_out("to0", 4'b0100, 2'd2, 1'b1);
      bus.req = 4'b1100;
`ifdef ARB_TIMEOUT_EN
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_val("to_wait", 32'(bus.timeout), 32'd0);
         check_val("to_wait_gnt", 32'(bus.gnt), 32'h4);
      end
      tick();
      check_val("to_pulse", 32'(bus.timeout), 32'd1);
      check_val("to_pulse_gnt", 32'(bus.gnt), 32'h4);
      tick();
      check_val("to_after", 32'(bus.timeout), 32'd0);
      check_out("to_regrant", 4'b1000, 2'd3, 1'b1);
`else
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_val("nto_flag", 32'(bus.timeout), 32'd0);
         check_val("nto_gnt", 32'(bus.gnt), 32'h4);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_out("nto_regrant", 4'b1000, 2'd3, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares one memory/datapath port between four requesters (0 = instruction fetch, 1 = MEM-stage load/store, 2 = debug, 3 = spare). It drives the 2-bit select of the port's existing 4:1 n-bit input mux and issues one-hot grants. A grant is held until the shared port signals transaction completion. Sits between the pipeline stages and the single-ported memory wrapper.

Parameters:
HOLD_MAX, 255, max cycles a grant may be held before timeout (used only with ARB_TIMEOUT_EN); must be >= 1
CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > HOLD_MAX

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req  input  4  request per requester; level, bit i = requester i
done  input  1  shared port completed the current transaction (1-cycle pulse)
gnt  output  4  one-hot grant, registered
sel  output  2  mux select = index of current/last winner, registered
busy  output  1  a grant is active
timeout  output  1  1-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, gnt=0, sel=0, busy=0, timeout=0, ptr=0, hold_cnt=0. Reset mid-grant drops the grant at that edge; no completion is recorded.
- ptr = highest-priority index for the next arbitration; search order ptr, ptr+1, ... modulo 4.
- States: IDLE, GRANT.
- IDLE: if req!=0, the winner w is the first set bit in search order. Next edge: gnt=onehot(w), sel=w, busy=1, state=GRANT, hold_cnt=0. Latency req->gnt is 1 cycle. If req==0, remain in IDLE; sel keeps the last winner and gnt=0.
- GRANT: gnt and sel are held stable regardless of req. Deassertion of req by the winner before done is ignored. hold_cnt increments each cycle and saturates.
- GRANT with done=1: ptr <= (w+1) mod 4. Re-arbitration happens in the same cycle using the updated ptr and the current req, with no bubble.
  - If any req is set, the next edge grants the new winner directly; state stays GRANT and hold_cnt=0.
  - If req==0, the next edge gives gnt=0, busy=0, state=IDLE, and sel holds.
  - The finishing requester keeps req high only if it wants another transaction. It is re-granted only when no other requester is pending, since it has the lowest priority after ptr rotation.
- done in IDLE is ignored.
- All four requesters active continuously: grants rotate 0,1,2,3,0,... with one grant per done.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit while busy=1.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: in GRANT, if hold_cnt reaches HOLD_MAX-1 with done=0, the arbiter treats the next edge as a forced completion. timeout pulses 1 for one cycle, ptr rotates, and re-arbitration happens exactly as for done.
- Undefined: no hold_cnt logic, timeout is tied 0, and a grant is held indefinitely until done.

Decomposition:
- Package mem_arb_pkg: N_REQ=4, SEL_W=2, and state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1.
- One combinational sub-module, rr_priority_pick.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: valid, idx[1:0].
  - Function: rotate-by-ptr priority encoder.
- Top level holds the FSM, ptr, hold counter and output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111. Expect gnt=0, sel=0, busy=0. Release reset: gnt=4'b0001, sel=0 one cycle later.
- Single requester: req=4'b0100 from IDLE. Next cycle gnt=4'b0100, sel=2, busy=1. Pulse done with req=0: next cycle gnt=0, busy=0, sel stays 2.
- Fairness: req=4'b1111 held, done pulsed every 3rd cycle. Expect sel sequence 0,1,2,3,0 and no idle cycle between grants.
- Hold-through: granted requester 1 drops req mid-transaction while req[3]=1. gnt stays 4'b0010 until done. Next cycle gnt=4'b1000.
- Lone re-request: only req[0]=1 and held across done. Expect gnt=4'b0001 continuously with ptr advancing to 1. Then assert req[1]: granted at the next done.
- ARB_TIMEOUT_EN with HOLD_MAX=4: grant requester 2, never pulse done, req[3]=1. timeout=1 exactly 4 cycles after the grant, and gnt=4'b1000 on the following edge.
